// File: rtl/comp_fir_pkg.sv
// Shared constants, coefficient ROM and FSM encoding for the CIC droop-compensation FIR.
package comp_fir_pkg;

  localparam int NTAPS_DEF  = 32;
  localparam int COEF_W_DEF = 16;

  // Symmetric Q1.15 taps; DC gain is sum(COEF) / 2^15 = 4706 / 32768.
  localparam logic signed [COEF_W_DEF-1:0] COEF [0:NTAPS_DEF-1] = '{
    -16'sd8,    -16'sd21,   16'sd14,    16'sd52,    -16'sd33,   -16'sd110,  16'sd61,    16'sd208,
    -16'sd97,   -16'sd362,  16'sd134,   16'sd605,   -16'sd160,  -16'sd1050, 16'sd120,   16'sd3000,
    16'sd3000,  16'sd120,   -16'sd1050, -16'sd160,  16'sd605,   16'sd134,   -16'sd362,  -16'sd97,
    16'sd208,   16'sd61,    -16'sd110,  -16'sd33,   16'sd52,    16'sd14,    -16'sd21,   -16'sd8
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MAC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/comp_fir_mac.sv
// Multiply-accumulate datapath plus round / shift / width-reduction output register.
// FIR_SAT_EN defined: clamp to the OUT_W signed range; otherwise wrap two's complement.
module comp_fir_mac #(
  parameter int IN_W   = 33,
  parameter int COEF_W = 16,
  parameter int ACC_W  = 54,
  parameter int SHIFT  = 15,
  parameter int OUT_W  = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr,
  input  logic                     en,
  input  logic                     out_en,
  input  logic signed [IN_W-1:0]   sample,
  input  logic signed [COEF_W-1:0] coef,
  output logic signed [OUT_W-1:0]  out,
  output logic                     out_valid
);

  localparam int PROD_W = IN_W + COEF_W;
  localparam int RND_W  = ACC_W + 1;
  localparam logic [RND_W-1:0] HALF =
    (SHIFT > 0) ? (RND_W'(1'b1) << ((SHIFT > 0) ? (SHIFT - 1) : 0)) : '0;

  logic signed [PROD_W-1:0] prod_s;
  logic signed [ACC_W-1:0]  acc_r;
  logic signed [RND_W-1:0]  rnd_s;
  logic signed [RND_W-1:0]  sh_s;
  logic signed [OUT_W-1:0]  res_s;
  logic signed [OUT_W-1:0]  out_r;
  logic                     out_valid_r;

  function automatic logic signed [OUT_W-1:0] reduce_out(input logic signed [RND_W-1:0] v);
`ifdef FIR_SAT_EN
    logic signed [RND_W-1:0] max_v;
    logic signed [RND_W-1:0] min_v;
    max_v = RND_W'({1'b0, {(OUT_W-1){1'b1}}});
    min_v = ~max_v;
    if (v > max_v) begin
      return max_v[OUT_W-1:0];
    end else if (v < min_v) begin
      return min_v[OUT_W-1:0];
    end else begin
      return v[OUT_W-1:0];
    end
`else
    return v[OUT_W-1:0];
`endif
  endfunction

  assign prod_s = PROD_W'(sample) * PROD_W'(coef);
  // One guard bit above the accumulator so the rounding add cannot overflow.
  assign rnd_s  = RND_W'(acc_r) + $signed(HALF);
  assign sh_s   = rnd_s >>> SHIFT;

  // Final width reduction of the rounded, shifted accumulator.
  always_comb begin
    res_s = reduce_out(sh_s);
  end

  // Accumulator and registered output sample / strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_r       <= '0;
      out_r       <= '0;
      out_valid_r <= 1'b0;
    end else begin
      if (clr) begin
        acc_r <= '0;
      end else if (en) begin
        acc_r <= acc_r + ACC_W'(prod_s);
      end
      if (out_en) begin
        out_r       <= res_s;
        out_valid_r <= 1'b1;
      end else begin
        out_valid_r <= 1'b0;
      end
    end
  end

  assign out       = out_r;
  assign out_valid = out_valid_r;

endmodule

// File: rtl/comp_fir.sv
// CIC droop-compensation FIR with decimate-by-DEC over a circular sample history.
// Optional macro FIR_SAT_EN: saturate the output instead of wrapping.
module comp_fir
  import comp_fir_pkg::*;
#(
  parameter int IN_W   = 33,
  parameter int COEF_W = COEF_W_DEF,
  parameter int NTAPS  = NTAPS_DEF,
  parameter int DEC    = 2,
  parameter int SHIFT  = 15,
  parameter int OUT_W  = 24
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic signed [IN_W-1:0]  in,
  input  logic                    in_valid,
  output logic signed [OUT_W-1:0] out,
  output logic                    out_valid,
  output logic                    busy,
  output logic                    overrun
);

  localparam int PTR_W = (clog2(NTAPS) > 0) ? clog2(NTAPS) : 1;
  localparam int PH_W  = (clog2(DEC) > 0) ? clog2(DEC) : 1;
  localparam int ACC_W = IN_W + COEF_W + clog2(NTAPS);
  localparam logic [PTR_W-1:0] LAST_K  = PTR_W'(NTAPS - 1);
  localparam logic [PH_W-1:0]  LAST_PH = PH_W'(DEC - 1);

  state_t                  state_r;
  state_t                  state_s;
  logic [PTR_W-1:0]        wr_ptr_r;
  logic [PTR_W-1:0]        base_r;
  logic [PTR_W-1:0]        k_r;
  logic [PTR_W-1:0]        rd_idx_s;
  logic [PH_W-1:0]         ph_r;
  logic signed [IN_W-1:0]  hist_r [0:NTAPS-1];
  logic signed [IN_W-1:0]  sample_s;
  logic signed [COEF_W-1:0] coef_s;
  logic                    overrun_r;
  logic                    accept_s;
  logic                    clr_s;
  logic                    en_s;
  logic                    out_en_s;

  // Next-state and per-cycle controls for the accept / MAC / output sequence.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    clr_s    = 1'b0;
    en_s     = 1'b0;
    out_en_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          accept_s = 1'b1;
          if (ph_r == LAST_PH) begin
            state_s = MAC;
            clr_s   = 1'b1;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      MAC: begin
        en_s = 1'b1;
        if (k_r == LAST_K) begin
          state_s = OUT;
        end else begin
          state_s = MAC;
        end
      end
      OUT: begin
        out_en_s = 1'b1;
        state_s  = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Tap k reads the sample k positions older than the newest one, modulo NTAPS.
  always_comb begin
    if (base_r >= k_r) begin
      rd_idx_s = base_r - k_r;
    end else begin
      rd_idx_s = PTR_W'(int'(base_r) + NTAPS - int'(k_r));
    end
  end

  assign sample_s = hist_r[rd_idx_s];
  assign coef_s   = COEF_W'(COEF[k_r]);

  // FSM state, history writes, ring/phase pointers and the sticky overrun flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= IDLE;
      wr_ptr_r  <= '0;
      base_r    <= '0;
      k_r       <= '0;
      ph_r      <= '0;
      overrun_r <= 1'b0;
      for (int i = 0; i < NTAPS; i++) begin
        hist_r[i] <= '0;
      end
    end else begin
      state_r <= state_s;
      if (accept_s) begin
        hist_r[wr_ptr_r] <= in;
        base_r           <= wr_ptr_r;
        wr_ptr_r         <= (wr_ptr_r == LAST_K) ? '0 : wr_ptr_r + PTR_W'(1'b1);
        ph_r             <= (ph_r == LAST_PH) ? '0 : ph_r + PH_W'(1'b1);
      end
      if (clr_s) begin
        k_r <= '0;
      end else if (en_s) begin
        k_r <= k_r + PTR_W'(1'b1);
      end
      if (in_valid && (state_r != IDLE)) begin
        overrun_r <= 1'b1;
      end
    end
  end

  comp_fir_mac #(
    .IN_W   (IN_W),
    .COEF_W (COEF_W),
    .ACC_W  (ACC_W),
    .SHIFT  (SHIFT),
    .OUT_W  (OUT_W)
  ) u_mac (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr_s),
    .en        (en_s),
    .out_en    (out_en_s),
    .sample    (sample_s),
    .coef      (coef_s),
    .out       (out),
    .out_valid (out_valid)
  );

  assign busy    = (state_r != IDLE);
  assign overrun = overrun_r;

endmodule

// File: tb/tb_comp_fir.sv
// Scoreboard bench for comp_fir: SHIFT=0 and SHIFT=15 instances share one stimulus stream.
module tb_comp_fir;

  localparam int C [0:31] = '{
    -8, -21, 14, 52, -33, -110, 61, 208, -97, -362, 134, 605, -160, -1050, 120, 3000,
    3000, 120, -1050, -160, 605, 134, -362, -97, 208, 61, -110, -33, 52, 14, -21, -8
  };
  localparam int IMP [0:15] = '{
    -21, 52, -110, 208, -362, 605, -1050, 3000, 120, -160, 134, -97, 61, -33, 14, -8
  };
  localparam longint DC_HAND = 4706000;
`ifdef FIR_SAT_EN
  localparam longint SAT_HAND = 8388607;
`else
  localparam longint SAT_HAND = 0;
`endif

  logic               clk;
  logic               rst;
  logic signed [32:0] in_s;
  logic               in_valid_s;
  logic signed [23:0] out0, out15;
  logic               ov0, ov15, busy0, busy15, orun0, orun15;

  int     checks = 0;
  int     passes = 0;
  longint q0[$];
  longint q15[$];
  longint ref_hist [0:31];
  int     ref_ptr;
  int     ref_ph;

  comp_fir #(.SHIFT(0)) dut0 (
    .clk(clk), .rst(rst), .in(in_s), .in_valid(in_valid_s),
    .out(out0), .out_valid(ov0), .busy(busy0), .overrun(orun0)
  );

  comp_fir #(.SHIFT(15)) dut15 (
    .clk(clk), .rst(rst), .in(in_s), .in_valid(in_valid_s),
    .out(out15), .out_valid(ov15), .busy(busy15), .overrun(orun15)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic longint red24(input longint v);
`ifdef FIR_SAT_EN
    if (v > 64'sd8388607) return 64'sd8388607;
    else if (v < -64'sd8388608) return -64'sd8388608;
    else return v;
`else
    logic [23:0] b;
    b = v[23:0];
    return longint'($signed(b));
`endif
  endfunction

  function automatic longint fir_acc(input int base);
    longint a;
    a = 0;
    for (int k = 0; k < 32; k++) a += longint'(C[k]) * ref_hist[(base - k + 32) % 32];
    return a;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 32; k++) ref_hist[k] = 0;
    ref_ptr = 0;
    ref_ph  = 0;
  endtask

  // Record an accepted sample; on every second one push the expected outputs.
  task automatic model_accept(input longint s, input bit hand, input longint hv);
    longint acc;
    ref_hist[ref_ptr] = s;
    if (ref_ph == 1) begin
      acc = fir_acc(ref_ptr);
      q0.push_back(hand ? hv : red24(acc));
      q15.push_back(red24((acc + 64'sd16384) >>> 15));
      ref_ph = 0;
    end else begin
      ref_ph = 1;
    end
    ref_ptr = (ref_ptr + 1) % 32;
  endtask

  task automatic send(input longint s, input bit hand, input longint hv);
    @(negedge clk);
    in_s = s[32:0];
    in_valid_s = 1'b1;
    @(negedge clk);
    in_valid_s = 1'b0;
    model_accept(s, hand, hv);
    repeat (62) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    in_valid_s = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    model_reset();
  endtask

  // Monitor: every output strobe is compared against the head of its queue.
  always @(negedge clk) begin
    if (ov0) begin
      if (q0.size() == 0) begin
        checks++;
        $display("FAIL unexpected_out0: got %0d, expected no output", out0);
      end else begin
        check("out0", longint'(out0), q0.pop_front());
      end
    end
    if (ov15) begin
      if (q15.size() == 0) begin
        checks++;
        $display("FAIL unexpected_out15: got %0d, expected no output", out15);
      end else begin
        check("out15", longint'(out15), q15.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b0;
    in_valid_s = 1'b0;
    in_s = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_out", longint'(out0), 0);
    check("reset_out_valid", longint'(ov0), 0);
    check("reset_busy", longint'(busy0), 0);
    check("reset_overrun", longint'(orun0), 0);
    @(posedge clk);
    #2 rst = 1'b1;

    // Impulse: output n = COEF[2n+1], then zero.
    for (int i = 0; i < 34; i++)
      send((i == 0) ? 1 : 0, (i % 2) == 1, ((i / 2) < 16) ? longint'(IMP[(i / 2) % 16]) : 0);
    check("impulse_drained", q0.size(), 0);

    // DC: steady state equals 1000 * sum(COEF).
    for (int i = 0; i < 40; i++) send(1000, ((i % 2) == 1) && ((i / 2) >= 16), DC_HAND);
    check("dc_drained", q0.size(), 0);

    // Reset in the middle of a MAC run: nothing may come out of that frame.
    @(negedge clk); in_s = 33'sd777; in_valid_s = 1'b1;
    @(negedge clk); in_valid_s = 1'b0;
    repeat (62) @(negedge clk);
    @(negedge clk); in_s = -33'sd999; in_valid_s = 1'b1;
    @(posedge clk);
    @(negedge clk); in_valid_s = 1'b0;
    repeat (10) @(posedge clk);
    #1 check("busy_before_abort", longint'(busy0), 1);
    #1 rst = 1'b0;
    #1;
    check("abort_out", longint'(out0), 0);
    check("abort_out_valid", longint'(ov0), 0);
    check("abort_busy", longint'(busy0), 0);
    check("abort_overrun", longint'(orun0), 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    model_reset();
    repeat (40) @(negedge clk);

    // Latency / handshake; history must be clean after the abort.
    send(300, 1'b0, 0);
    @(negedge clk); in_s = -33'sd500; in_valid_s = 1'b1;
    @(posedge clk);
    @(negedge clk); in_valid_s = 1'b0;
    model_accept(-500, 1'b1, -2300);
    check("busy_t1", longint'(busy0), 1);
    for (int i = 1; i <= 34; i++) begin
      @(posedge clk);
      #1;
      if (i == 32 || i == 33) check("busy_edge", longint'(busy0), (i == 32) ? 1 : 0);
      if (i >= 32) check("out_valid_edge", longint'(ov0), (i == 33) ? 1 : 0);
    end
    repeat (40) @(negedge clk);
    check("latency_drained", q0.size(), 0);

    // Saturation / wrap with a full-scale-ish constant input.
    do_reset();
    for (int i = 0; i < 36; i++)
      send(64'sd2147483648, ((i % 2) == 1) && ((i / 2) >= 16), SAT_HAND);
    check("sat_drained", q0.size(), 0);

    // Overrun: a sample 5 clocks after the trigger is dropped and flagged.
    do_reset();
    send(11, 1'b0, 0);
    @(negedge clk); in_s = 33'sd22; in_valid_s = 1'b1;
    @(posedge clk);
    @(negedge clk); in_valid_s = 1'b0;
    model_accept(22, 1'b1, -407);
    check("overrun_before", longint'(orun0), 0);
    repeat (4) @(negedge clk);
    in_s = 33'sd5000; in_valid_s = 1'b1;
    @(negedge clk); in_valid_s = 1'b0;
    check("overrun_set", longint'(orun0), 1);
    check("overrun_set15", longint'(orun15), 1);
    repeat (58) @(negedge clk);
    send(7, 1'b0, 0);
    send(-3, 1'b0, 0);
    send(9, 1'b0, 0);
    send(4, 1'b0, 0);
    check("overrun_sticky", longint'(orun0), 1);
    check("final_q0_empty", q0.size(), 0);
    check("final_q15_empty", q15.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
